// File: rtl/quickq_pkg.sv
// Shared types and sizing helpers for the QuickQ front-end scheduler.
package quickq_pkg;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_GAP} sched_state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ} op_e;

  localparam int QQ_DEPTH = 64;
  localparam int QQ_COUNT_W = $clog2(QQ_DEPTH + 1);

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/quickq_rr_arb2.sv
// Two-requester round-robin arbiter; after each grant the pointer favors the loser.
module quickq_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_q;

  // ptr_q == 0 favors req[0] when both sides request
  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !ptr_q)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (grant != 2'b00) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/quickq_op_scheduler.sv
// Arbitrates enqueue/dequeue requests into spaced head-node commands, tracks
// occupancy, returns dequeued keys after the chain latency and scrubs the chain.
module quickq_op_scheduler
  import quickq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = QQ_DEPTH,
  parameter int OP_GAP     = 2,
  parameter int DEQ_LAT    = 3,
  parameter int CLR_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset_n_i,
  input  logic                         enq_valid_i,
  input  logic [DATA_W-1:0]            enq_data_i,
  output logic                         enq_ready_o,
  input  logic                         deq_valid_i,
  output logic                         deq_ready_o,
  input  logic                         clr_i,
  output logic                         rsp_valid_o,
  output logic [DATA_W-1:0]            rsp_data_o,
  output logic                         node_write_o,
  output logic                         node_read_o,
  output logic                         node_reset_o,
  output logic [DATA_W-1:0]            node_data_o,
  input  logic [DATA_W-1:0]            node_data_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         busy_o
);

  localparam int CNT_W = count_w(DEPTH);
  localparam int GAP_W = $clog2(OP_GAP + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(OP_GAP - 1);
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES);

  sched_state_e       state_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [CLR_W-1:0]   clr_cnt_q;
  logic               clr_pend_q;
  logic [CNT_W-1:0]   count_q;
  logic [DEQ_LAT-1:0] tok_q;

  logic       full, empty, clr_req, pipe_busy, grant_open;
  logic [1:0] arb_req, arb_grant;
  op_e        grant_op;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign clr_req    = clr_i || clr_pend_q;
  assign pipe_busy  = node_read_o || (|tok_q);
  assign grant_open = (state_q == S_IDLE) && !clr_req;
  assign arb_req    = {deq_valid_i && !empty, enq_valid_i && !full} & {2{grant_open}};

  quickq_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset_n_i),
    .req   (arb_req),
    .grant (arb_grant)
  );

  assign enq_ready_o = arb_grant[0];
  assign deq_ready_o = arb_grant[1];

  always_comb begin
    grant_op = OP_NONE;
    if (arb_grant[0]) begin
      grant_op = OP_ENQ;
    end else if (arb_grant[1]) begin
      grant_op = OP_DEQ;
    end
  end

  // node_reset_o lags the post-reset S_CLEAR entry by one cycle so it stays low
  // while reset is asserted; the clear counter waits for it before counting.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= CLR_LOAD;
      gap_cnt_q    <= '0;
      clr_pend_q   <= 1'b0;
      count_q      <= '0;
      node_write_o <= 1'b0;
      node_read_o  <= 1'b0;
      node_reset_o <= 1'b0;
      node_data_o  <= '0;
    end else begin
      node_write_o <= 1'b0;
      node_read_o  <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (!node_reset_o) begin
            node_reset_o <= 1'b1;
          end else if (clr_cnt_q == CLR_W'(1)) begin
            state_q      <= S_IDLE;
            node_reset_o <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q - CLR_W'(1);
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            if (!pipe_busy) begin
              state_q      <= S_CLEAR;
              clr_cnt_q    <= CLR_LOAD;
              node_reset_o <= 1'b1;
              clr_pend_q   <= 1'b0;
              count_q      <= '0;
            end else begin
              clr_pend_q <= 1'b1;
            end
          end else if (grant_op != OP_NONE) begin
            if (OP_GAP > 1) begin
              state_q   <= S_GAP;
              gap_cnt_q <= GAP_LOAD;
            end
            if (grant_op == OP_ENQ) begin
              node_write_o <= 1'b1;
              node_data_o  <= enq_data_i;
              count_q      <= count_q + CNT_W'(1);
            end else begin
              node_read_o <= 1'b1;
              count_q     <= count_q - CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (clr_i) begin
            clr_pend_q <= 1'b1;
          end
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Read tokens follow node_read_o down the chain latency, then capture the key.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tok_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      tok_q       <= (tok_q << 1) | DEQ_LAT'(node_read_o);
      rsp_valid_o <= tok_q[DEQ_LAT-1];
      if (tok_q[DEQ_LAT-1]) begin
        rsp_data_o <= node_data_i;
      end
    end
  end

  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_quickq_op_scheduler.sv
// Randomized scoreboard bench for quickq_op_scheduler with a FIFO reference model
// and a behavioural head-node chain that returns keys after DEQ_LAT cycles.
module tb_quickq_op_scheduler;

  localparam int DATA_W     = 16;
  localparam int DEPTH      = quickq_pkg::QQ_DEPTH;
  localparam int OP_GAP     = 2;
  localparam int DEQ_LAT    = 3;
  localparam int CLR_CYCLES = 64;
  localparam int CNT_W      = quickq_pkg::QQ_COUNT_W;
  localparam int FAR        = 1000000;

  logic              clk = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              enq_valid_i = 1'b0;
  logic [DATA_W-1:0] enq_data_i = '0;
  logic              enq_ready_o;
  logic              deq_valid_i = 1'b0;
  logic              deq_ready_o;
  logic              clr_i = 1'b0;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              node_write_o, node_read_o, node_reset_o;
  logic [DATA_W-1:0] node_data_o;
  logic [DATA_W-1:0] node_data_i = '0;
  logic [CNT_W-1:0]  count_o;
  logic              full_o, empty_o, busy_o;

  quickq_op_scheduler #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .OP_GAP(OP_GAP), .DEQ_LAT(DEQ_LAT), .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .enq_valid_i(enq_valid_i), .enq_data_i(enq_data_i), .enq_ready_o(enq_ready_o),
    .deq_valid_i(deq_valid_i), .deq_ready_o(deq_ready_o), .clr_i(clr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .node_write_o(node_write_o), .node_read_o(node_read_o), .node_reset_o(node_reset_o),
    .node_data_o(node_data_o), .node_data_i(node_data_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic [DATA_W-1:0] model_q[$];
  exp_t              exp_q[$];
  logic [DATA_W-1:0] chain_q[$];
  logic [DATA_W:0]   node_pipe[$];

  int tests_run = 0;
  int tests_failed = 0;
  int last_grant = -FAR;
  int last_deq = -FAR;
  int scrub_start = FAR;
  int scrub_done = FAR;
  int clear_at = -1;
  bit favor_enq = 1'b1;
  bit deq_granted = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Head node behaves as a FIFO whose read data appears DEQ_LAT cycles after the strobe.
  always @(negedge clk) begin : chain_model
    logic [DATA_W:0] item;
    item = '0;
    if (node_reset_o) chain_q.delete();
    if (node_write_o) chain_q.push_back(node_data_o);
    if (node_read_o && chain_q.size() > 0) item = {1'b1, chain_q.pop_front()};
    node_pipe.push_back(item);
    if (node_pipe.size() > DEQ_LAT) begin
      item = node_pipe.pop_front();
      node_data_i = item[DATA_W] ? item[DATA_W-1:0] : DATA_W'($urandom);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (clear_at >= 0 && cyc >= clear_at) begin
      model_q.delete();
      clear_at = -1;
    end
    if (!reset_n_i) begin
      checkOutput("rst_node_reset", node_reset_o, 0);
      checkOutput("rst_strobes", {node_write_o, node_read_o}, 0);
      checkOutput("rst_rsp_valid", rsp_valid_o, 0);
      checkOutput("rst_count", count_o, 0);
      checkOutput("rst_readies", {enq_ready_o, deq_ready_o}, 0);
    end else begin
      checkOutput("node_reset", node_reset_o, (cyc >= scrub_start && cyc < scrub_start + CLR_CYCLES));
      if (cyc >= scrub_start && cyc < scrub_start + CLR_CYCLES) checkOutput("busy_scrub", busy_o, 1);
      checkOutput("count", count_o, model_q.size());
      checkOutput("full", full_o, model_q.size() == DEPTH);
      checkOutput("empty", empty_o, model_q.size() == 0);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checkOutput("rsp_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_cycle", cyc, e.due);
          checkOutput("rsp_data", rsp_data_o, e.data);
        end
      end
    end
  end

  // One clock of stimulus: drive at negedge, check readies, grant at posedge, check strobes.
  task automatic applyStimulus(input int p_enq, input int p_deq, input int p_clr, input bit force_clr);
    int g, entry;
    bit do_clr, allowed, enq_el, deq_el, exp_enq, exp_deq;
    @(negedge clk);
    g = cyc + 1;
    enq_valid_i = ($urandom_range(99) < p_enq);
    deq_valid_i = ($urandom_range(99) < p_deq);
    enq_data_i  = DATA_W'($urandom);
    do_clr = force_clr || ($urandom_range(999) < p_clr);
    if (g < scrub_done) do_clr = 1'b0;
    clr_i = do_clr;
    if (do_clr) begin
      entry = max2(g, max2(last_grant + OP_GAP, last_deq + DEQ_LAT + 2));
      scrub_start = entry;
      scrub_done  = entry + CLR_CYCLES + 1;
      clear_at    = entry;
    end
    allowed = (g >= scrub_done) && (g >= last_grant + OP_GAP);
    enq_el  = enq_valid_i && (model_q.size() < DEPTH);
    deq_el  = deq_valid_i && (model_q.size() > 0);
    exp_enq = allowed && enq_el && (!deq_el || favor_enq);
    exp_deq = allowed && deq_el && !exp_enq;
    #1;
    checkOutput("enq_ready", enq_ready_o, exp_enq);
    checkOutput("deq_ready", deq_ready_o, exp_deq);
    @(posedge clk);
    if (exp_enq) begin
      model_q.push_back(enq_data_i);
      last_grant = g;
      favor_enq  = 1'b0;
    end
    if (exp_deq) begin
      exp_q.push_back('{data: model_q.pop_front(), due: g + DEQ_LAT + 1});
      last_grant = g;
      last_deq   = g;
      favor_enq  = 1'b1;
    end
    deq_granted = exp_deq;
    #1;
    checkOutput("node_write", node_write_o, exp_enq);
    if (exp_enq) checkOutput("node_data", node_data_o, enq_data_i);
    checkOutput("node_read", node_read_o, exp_deq);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #2;
    reset_n_i   = 1'b1;
    scrub_start = cyc + 1;
    scrub_done  = cyc + 1 + CLR_CYCLES + 1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    enq_valid_i = 1'b0;
    deq_valid_i = 1'b0;
    clr_i       = 1'b0;
    reset_n_i   = 1'b0;
    model_q.delete();
    exp_q.delete();
    clear_at    = -1;
    last_grant  = -FAR;
    last_deq    = -FAR;
    favor_enq   = 1'b1;
    scrub_start = FAR;
    scrub_done  = FAR;
    releaseReset();
  endtask

  task automatic waitForDeqGrant(input string name);
    int n;
    n = 0;
    deq_granted = 1'b0;
    while (!deq_granted && n < 300) begin
      applyStimulus(60, 60, 0, 1'b0);
      n++;
    end
    if (!deq_granted) checkOutput(name, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    releaseReset();
    for (int i = 0; i < 80; i++) applyStimulus(90, 20, 0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(100, 30, 0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(30, 100, 0, 1'b0);

    waitForDeqGrant("clr_setup_timeout");
    applyStimulus(60, 60, 0, 1'b1);
    for (int i = 0; i < 120; i++) applyStimulus(80, 50, 0, 1'b0);

    for (int i = 0; i < 400; i++) applyStimulus(50, 50, 5, 1'b0);

    for (int i = 0; i < 40; i++) applyStimulus(100, 0, 0, 1'b0);
    waitForDeqGrant("reset_setup_timeout");
    pulseReset();
    for (int i = 0; i < 120; i++) applyStimulus(70, 40, 0, 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1'b0);
    checkOutput("rsp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/quickq_op_scheduler.md
# quickq_op_scheduler

Front-end sequencer for the QuickQ node chain. Accepts enqueue and dequeue requests from two independent requesters and arbitrates between them. Issues single-cycle write/read/reset commands into the head node, spaced so the chain's per-node BRAM read-modify-write completes. Tracks occupancy and returns dequeued values after the fixed chain latency, and scrubs the chain after reset or on a clear command.

## Interface
- DATA_W, 16, key width carried through the chain
- DEPTH, 64, queue capacity in entries
- OP_GAP, 2, minimum cycles between successive issued commands (≥1)
- DEQ_LAT, 3, cycles from node_read_o to valid data on node_data_i (≥1)
- CLR_CYCLES, 64, cycles node_reset_o is held during a scrub (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- enq_valid_i  in  1  enqueue request
- enq_data_i  in  DATA_W  key to enqueue
- enq_ready_o  out  1  enqueue accepted this cycle when high with enq_valid_i
- deq_valid_i  in  1  dequeue request
- deq_ready_o  out  1  dequeue accepted this cycle when high with deq_valid_i
- clr_i  in  1  single-cycle clear request
- rsp_valid_o  out  1  one-cycle pulse, dequeued key valid; no backpressure
- rsp_data_o  out  DATA_W  dequeued key
- node_write_o / node_read_o / node_reset_o  out  1  head-node command strobes
- node_data_o  out  DATA_W  key driven with node_write_o
- node_data_i  in  DATA_W  head-node output data
- count_o  out  $clog2(DEPTH+1)  current occupancy
- full_o, empty_o, busy_o  out  1  count==DEPTH, count==0, state≠S_IDLE

## Operation
- States: S_CLEAR, S_IDLE, S_GAP.
- Reset asserted: state=S_CLEAR, clear counter=CLR_CYCLES, count_o=0, all strobes and rsp_valid_o=0, node_data_o=0, rsp_data_o=0, arbiter pointer favors enqueue, in-flight read pipeline cleared, clear-pending=0.
- S_CLEAR: node_reset_o=1 every cycle. Counter decrements; at 1, go to S_IDLE. Both readies are 0.
- S_IDLE:
  - Eligibility: enqueue is eligible when enq_valid_i && !full. Dequeue is eligible when deq_valid_i && !empty.
  - Pending clear (clr_i or clear-pending) has priority. Both readies are 0. Enter S_CLEAR only once the read pipeline is empty; otherwise hold clear-pending. count_o is zeroed on entry.
  - Otherwise, with one side eligible, that side gets ready=1. With both eligible, the round-robin pointer decides. The pointer flips to the loser after every grant.
  - Ready outputs are combinational from state, count, valids and pointer.
  - On a grant, go to S_GAP with gap counter=OP_GAP-1. If OP_GAP==1, stay in S_IDLE.
- S_GAP: readies are 0. Count down, then return to S_IDLE. A clr_i arriving here sets clear-pending.
- Enqueue grant: node_write_o=1 and node_data_o=enq_data_i next cycle; count_o+1.
- Dequeue grant: node_read_o=1 next cycle; count_o-1. A token enters a DEQ_LAT-deep shift register.
- Count never wraps; readies guarantee 0≤count_o≤DEPTH.

## Timing
- Grant at edge t: command strobe high during cycle t+1 only. count_o/full_o/empty_o update at t+1.
- Dequeue granted at t: node_data_i sampled at end of cycle t+1+DEQ_LAT. rsp_valid_o/rsp_data_o are registered, high during cycle t+2+DEQ_LAT.
- Consecutive grants are ≥OP_GAP cycles apart. Responses stay in grant order.
- Clear latency: S_CLEAR starts the cycle after the last in-flight response pulses. node_reset_o is high for exactly CLR_CYCLES cycles.
- Reset mid-operation: in-flight responses are discarded, and no rsp_valid_o occurs after reset. A full scrub runs after reset_n_i deasserts.
- clr_i during S_CLEAR is ignored.

## Structure
- Package quickq_pkg:
  - sched_state_e {S_CLEAR, S_IDLE, S_GAP}
  - op_e {OP_NONE, OP_ENQ, OP_DEQ}
  - count-width helper localparam
- Sub-module quickq_rr_arb2: two-requester round-robin with pointer register, grant one-hot out.
- Top holds the FSM, gap/clear counters, occupancy counter and read-token shift register.

## Test plan
- Reset release with defaults: node_reset_o high 64 cycles, then enq_ready_o=1 with enq_valid_i; count_o=0, empty_o=1 throughout.
- Enqueue 0x0005 at t: node_write_o and node_data_o=0x0005 at t+1, count_o=1. enq_ready_o=0 at t+1, 1 again at t+2 (OP_GAP=2).
- Both valid continuously with count_o=10: grants alternate ENQ, DEQ, ENQ…, one every 2 cycles. Each dequeue yields rsp_valid_o exactly 5 cycles after its grant, carrying node_data_i sampled at t+4.
- Fill to 64: full_o=1 and enq_ready_o=0 while dequeue is still granted. Drain to 0: empty_o=1 and deq_ready_o=0 while enqueue still wins with deq_valid_i high.
- clr_i one cycle after a dequeue grant: response still delivered. node_reset_o starts the following cycle, count_o=0, no grants for 64 cycles.
- reset_n_i pulsed low between a dequeue grant and its response: no rsp_valid_o, count_o=0, scrub restarts.
